mem_burst_seq: RTL and testbench

MEM_BURST_SEQ -- requirements
Module: mem_burst_seq

---
 rtl/mem_burst_seq.sv | 212 +++++++++++++++++++++
 tb/tb_mem_burst_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_seq.sv
// Burst memory sequencer: turns one read/write command into per-word memory
// requests with per-word timeout, bounded reissue and abort support.
module mem_burst_seq #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned RETRIES   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [$clog2(MAX_BURST+1)-1:0]   cmd_len,
  input  logic                             cmd_abort,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [DATA_W-1:0]                wr_data,
  output logic                             rd_valid,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             request,
  output logic                             request_type,
  output logic [ADDR_W-1:0]                request_address,
  output logic [DATA_W-1:0]                data_out,
  input  logic [DATA_W-1:0]                memory_in,
  input  logic                             memory_ready,
  input  logic                             write_complete,
  output logic                             done,
  output logic                             error,
  output logic                             aborted,
  output logic [$clog2(MAX_BURST+1)-1:0]   beats
);

  localparam int unsigned LEN_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RTY_W = 4;

  typedef enum logic [2:0] {IDLE, WDATA, ISSUE, WAIT, DONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [LEN_W-1:0]    len, len_n;
  logic                wr_mode, wr_mode_n;
  logic [TMR_W-1:0]    timer, timer_n;
  logic [RTY_W-1:0]    retry, retry_n;
  logic [LEN_W-1:0]    beats_n;
  logic                error_n, aborted_n;
  logic                request_n, request_type_n;
  logic [ADDR_W-1:0]   request_address_n;
  logic [DATA_W-1:0]   data_out_n, rd_data_n;
  logic                rd_valid_n, wr_ready_n, cmd_ready_n, done_n;

  logic [LEN_W-1:0]    len_clamp;
  logic [LEN_W-1:0]    beats_inc;
  logic                cplt;
  logic                tmo;

  assign len_clamp = (cmd_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : cmd_len;
  assign beats_inc = beats + LEN_W'(1);
  // Only the strobe matching the burst direction counts as completion.
  assign cplt      = wr_mode ? write_complete : memory_ready;
  assign tmo       = (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      addr            <= '0;
      len             <= '0;
      wr_mode         <= 1'b0;
      timer           <= '0;
      retry           <= '0;
      beats           <= '0;
      error           <= 1'b0;
      aborted         <= 1'b0;
      request         <= 1'b0;
      request_type    <= 1'b0;
      request_address <= '0;
      data_out        <= '0;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
      wr_ready        <= 1'b0;
      cmd_ready       <= 1'b1;
      done            <= 1'b0;
    end else begin
      state           <= state_n;
      addr            <= addr_n;
      len             <= len_n;
      wr_mode         <= wr_mode_n;
      timer           <= timer_n;
      retry           <= retry_n;
      beats           <= beats_n;
      error           <= error_n;
      aborted         <= aborted_n;
      request         <= request_n;
      request_type    <= request_type_n;
      request_address <= request_address_n;
      data_out        <= data_out_n;
      rd_valid        <= rd_valid_n;
      rd_data         <= rd_data_n;
      wr_ready        <= wr_ready_n;
      cmd_ready       <= cmd_ready_n;
      done            <= done_n;
    end
  end

  always_comb begin
    state_n           = state;
    addr_n            = addr;
    len_n             = len;
    wr_mode_n         = wr_mode;
    timer_n           = timer;
    retry_n           = retry;
    beats_n           = beats;
    error_n           = error;
    aborted_n         = aborted;
    data_out_n        = data_out;
    rd_data_n         = rd_data;
    rd_valid_n        = 1'b0;
    request_type_n    = request_type;
    request_address_n = request_address;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_n    = cmd_addr;
          wr_mode_n = cmd_write;
          len_n     = len_clamp;
          beats_n   = '0;
          error_n   = 1'b0;
          aborted_n = 1'b0;
          retry_n   = '0;
          if (len_clamp == '0) begin
            state_n = DONE;
          end else if (cmd_write) begin
            state_n = WDATA;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      WDATA: begin
        if (cmd_abort) begin
          aborted_n = 1'b1;
          state_n   = DONE;
        end else if (wr_valid && wr_ready) begin
          data_out_n = wr_data;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_abort) begin
          aborted_n = 1'b1;
          state_n   = DONE;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        // Abort wins over a same-cycle completion; completion wins over timeout.
        if (cmd_abort) begin
          aborted_n = 1'b1;
          state_n   = DONE;
        end else if (cplt) begin
          beats_n = beats_inc;
          addr_n  = addr + ADDR_W'(1);
          retry_n = '0;
          if (!wr_mode) begin
            rd_valid_n = 1'b1;
            rd_data_n  = memory_in;
          end
          if (beats_inc == len) begin
            state_n = DONE;
          end else if (wr_mode) begin
            state_n = WDATA;
          end else begin
            state_n = ISSUE;
          end
        end else if (tmo) begin
          if (retry < RTY_W'(RETRIES)) begin
            retry_n = retry + RTY_W'(1);
            state_n = ISSUE;
          end else begin
            error_n = 1'b1;
            state_n = DONE;
          end
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Registered outputs are derived from the state being entered.
    request_n = (state_n == ISSUE);
    if (request_n) begin
      request_address_n = addr_n;
      request_type_n    = wr_mode_n;
      timer_n           = '0;
    end
    done_n      = (state_n == DONE);
    cmd_ready_n = (state_n == IDLE);
    wr_ready_n  = (state_n == WDATA);
  end

endmodule

// File: tb/tb_mem_burst_seq.sv
// Bench for mem_burst_seq: directed table, randomized commands against a
// word/attempt-level reference model, and reset-in-flight sequence.
module tb_mem_burst_seq;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MB = 8;
  localparam int unsigned TO = 4;
  localparam int unsigned RT = 1;
  localparam int unsigned LW = $clog2(MB + 1);
  localparam int NV = 11;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_abort;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          request, request_type;
  logic [AW-1:0] request_address;
  logic [DW-1:0] data_out, memory_in;
  logic          memory_ready, write_complete;
  logic          done, error, aborted;
  logic [LW-1:0] beats;

  mem_burst_seq #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO), .RETRIES(RT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .request(request), .request_type(request_type),
    .request_address(request_address), .data_out(data_out),
    .memory_in(memory_in), .memory_ready(memory_ready),
    .write_complete(write_complete),
    .done(done), .error(error), .aborted(aborted), .beats(beats)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          typ;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            dly;
    logic          use_w;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    int            abort_no;
    int            nreq;
    int            nbeats;
    logic          err;
    logic          ab;
    logic [AW-1:0] a0;
    logic [AW-1:0] alast;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] dut_mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  int            cyc, rsp_cnt, dly_idx, wq_idx;
  logic          rsp_type;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_wdata;
  int            dly_q[$];
  logic [DW-1:0] wq[$];
  req_t          obs_req[$], exp_req[$];
  logic [DW-1:0] obs_rd[$], exp_rd[$];
  int            done_cnt, done_cyc, first_req_cyc, acc_cyc, viol, lat_err;
  int            abort_at, abort_no_g;
  logic [LW-1:0] obs_beats;
  logic          obs_err, obs_ab;
  logic          prev_req, prev_rdv, prev_done, legit_mr, chk_lat;
  logic          in_cmd, cur_write, wv_prev_ready;
  vec_t          tbl [NV];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, then drive memory, write feeder and abort.
  task automatic step();
    int d;
    @(negedge clk);
    cyc++;
    if (request && prev_req) viol++;
    if (rd_valid && prev_rdv) viol++;
    if (done && prev_done) viol++;
    prev_req  = request;
    prev_rdv  = rd_valid;
    prev_done = done;
    if (chk_lat && (rd_valid !== legit_mr)) lat_err++;
    if (rd_valid) obs_rd.push_back(rd_data);
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      obs_beats = beats;
      obs_err   = error;
      obs_ab    = aborted;
    end
    if (request) begin
      obs_req.push_back('{request_address, request_type, data_out});
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end

    memory_ready   = 1'b0;
    write_complete = 1'b0;
    legit_mr       = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        if (rsp_type) begin
          write_complete     = 1'b1;
          dut_mem[rsp_addr]  = rsp_wdata;
        end else begin
          memory_ready = 1'b1;
          memory_in    = dut_mem[rsp_addr];
          legit_mr     = 1'b1;
        end
      end
    end
    if (request) begin
      d = (dly_idx < dly_q.size()) ? dly_q[dly_idx] : 0;
      dly_idx++;
      rsp_cnt   = d;
      rsp_type  = request_type;
      rsp_addr  = request_address;
      rsp_wdata = data_out;
    end
    // Wrong-direction strobes must have no effect.
    if (in_cmd) begin
      if (cur_write && !memory_ready && $urandom_range(7) == 0) begin
        memory_ready = 1'b1;
        memory_in    = 16'($urandom);
      end
      if (!cur_write && !write_complete && $urandom_range(7) == 0) write_complete = 1'b1;
    end

    if (wr_valid && wv_prev_ready) wq_idx++;
    wr_valid      = (wq_idx < wq.size()) && ($urandom_range(3) != 0);
    wr_data       = wr_valid ? wq[wq_idx] : 16'($urandom);
    wv_prev_ready = wr_ready;

    cmd_abort = (cyc == abort_at);
    if (request && abort_no_g > 0 && obs_req.size() == abort_no_g) abort_at = cyc + 1;
  endtask

  task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] ln,
                         input int fdly, input logic use_w, input logic [DW-1:0] w0,
                         input logic [DW-1:0] w1, input int abort_no);
    int n, d, guard, exp_beats;
    logic ok, exp_err;
    logic [AW-1:0] wa;
    n = (int'(ln) > int'(MB)) ? int'(MB) : int'(ln);
    dly_q.delete(); dly_idx = 0; wq.delete(); wq_idx = 0;
    obs_req.delete(); obs_rd.delete(); exp_req.delete(); exp_rd.delete();
    done_cnt = 0; viol = 0; lat_err = 0; first_req_cyc = -1; done_cyc = -1;
    abort_at = -1; abort_no_g = abort_no;
    for (int i = 0; i < n; i++) begin
      if (use_w && i == 0) wq.push_back(w0);
      else if (use_w && i == 1) wq.push_back(w1);
      else wq.push_back(16'($urandom));
    end

    // Reference: each word gets up to RT+1 attempts; a nonzero delay is a response within TO.
    exp_beats = 0;
    exp_err   = 1'b0;
    for (int i = 0; i < n && !exp_err; i++) begin
      wa = 16'(a + 16'(i));
      ok = 1'b0;
      for (int att = 0; att <= int'(RT) && !ok; att++) begin
        d = (fdly >= 0) ? fdly : (($urandom_range(4) == 0) ? 0 : int'($urandom_range(TO, 1)));
        dly_q.push_back(d);
        exp_req.push_back('{wa, wr, wq[i]});
        if (d != 0) ok = 1'b1;
      end
      if (!ok) begin
        exp_err = 1'b1;
      end else begin
        exp_beats++;
        if (wr) ref_mem[wa] = wq[i];
        else exp_rd.push_back(ref_mem[wa]);
      end
    end

    in_cmd    = 1'b1;
    cur_write = wr;
    chk_lat   = (abort_no == 0);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = ln;
    acc_cyc   = cyc;
    step();
    cmd_valid = 1'b0;
    cmd_len   = LW'($urandom);
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin
      step();
      guard++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    in_cmd = 1'b0;
    repeat (6) step();
    chk_lat = 1'b0;

    check("done_count", done_cnt, 1);
    check("pulse_rules", viol, 0);
    if (!wr && n > 0) check("req_latency", first_req_cyc, acc_cyc + 1);
    if (n == 0) check("done_latency", done_cyc, acc_cyc + 1);
    if (abort_no == 0) begin
      check("rd_latency", lat_err, 0);
      check("nreq", obs_req.size(), exp_req.size());
      for (int i = 0; i < obs_req.size() && i < exp_req.size(); i++) begin
        check("req_addr", obs_req[i].addr, exp_req[i].addr);
        check("req_type", obs_req[i].typ, exp_req[i].typ);
        if (exp_req[i].typ) check("req_data", obs_req[i].data, exp_req[i].data);
      end
      check("nrd", obs_rd.size(), exp_rd.size());
      for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
        check("rd_data", obs_rd[i], exp_rd[i]);
      check("beats", obs_beats, exp_beats);
      check("error", obs_err, exp_err);
      check("aborted", obs_ab, 0);
    end else begin
      for (int i = 0; i < n; i++) ref_mem[16'(a + 16'(i))] = dut_mem[16'(a + 16'(i))];
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    int nreq0;
    tbl[0]  = '{1'b0, 16'h0010, 4'd3,  2, 1'b0, 16'h0, 16'h0, 0, 3, 3, 1'b0, 1'b0, 16'h0010, 16'h0012};
    tbl[1]  = '{1'b1, 16'hFFFF, 4'd2,  1, 1'b1, 16'hAAAA, 16'h5555, 0, 2, 2, 1'b0, 1'b0, 16'hFFFF, 16'h0000};
    tbl[2]  = '{1'b0, 16'h0100, 4'd1,  0, 1'b0, 16'h0, 16'h0, 0, 2, 0, 1'b1, 1'b0, 16'h0100, 16'h0100};
    tbl[3]  = '{1'b0, 16'h0200, 4'd12, 1, 1'b0, 16'h0, 16'h0, 0, 8, 8, 1'b0, 1'b0, 16'h0200, 16'h0207};
    tbl[4]  = '{1'b0, 16'h0300, 4'd0,  1, 1'b0, 16'h0, 16'h0, 0, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0};
    tbl[5]  = '{1'b0, 16'hFFFE, 4'd3,  4, 1'b0, 16'h0, 16'h0, 0, 3, 3, 1'b0, 1'b0, 16'hFFFE, 16'h0000};
    tbl[6]  = '{1'b1, 16'h0400, 4'd8,  3, 1'b0, 16'h0, 16'h0, 0, 8, 8, 1'b0, 1'b0, 16'h0400, 16'h0407};
    tbl[7]  = '{1'b1, 16'h0500, 4'd3,  0, 1'b0, 16'h0, 16'h0, 0, 2, 0, 1'b1, 1'b0, 16'h0500, 16'h0500};
    tbl[8]  = '{1'b0, 16'h0600, 4'd4,  3, 1'b0, 16'h0, 16'h0, 2, 2, 1, 1'b0, 1'b1, 16'h0600, 16'h0601};
    tbl[9]  = '{1'b1, 16'h0700, 4'd0,  1, 1'b0, 16'h0, 16'h0, 0, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0};
    tbl[10] = '{1'b1, 16'h0800, 4'd3,  2, 1'b0, 16'h0, 16'h0, 1, 1, 0, 1'b0, 1'b1, 16'h0800, 16'h0800};

    for (int a = 0; a < 65536; a++) begin
      dut_mem[a] = 16'($urandom);
      ref_mem[a] = dut_mem[a];
    end
    cyc = 0; rsp_cnt = 0; dly_idx = 0; wq_idx = 0;
    rsp_type = 1'b0; rsp_addr = '0; rsp_wdata = '0;
    done_cnt = 0; done_cyc = -1; first_req_cyc = -1; acc_cyc = 0; viol = 0; lat_err = 0;
    abort_at = -1; abort_no_g = 0;
    obs_beats = '0; obs_err = 1'b0; obs_ab = 1'b0;
    prev_req = 1'b0; prev_rdv = 1'b0; prev_done = 1'b0; legit_mr = 1'b0; chk_lat = 1'b0;
    in_cmd = 1'b0; cur_write = 1'b0; wv_prev_ready = 1'b0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_abort = 1'b0; wr_valid = 1'b0; wr_data = '0; memory_in = '0;
    memory_ready = 1'b0; write_complete = 1'b0;

    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_request", request, 0);
    check("rst_request_type", request_type, 0);
    check("rst_request_address", request_address, 0);
    check("rst_data_out", data_out, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_aborted", aborted, 0);
    check("rst_beats", beats, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].dly, tbl[i].use_w,
              tbl[i].w0, tbl[i].w1, tbl[i].abort_no);
      check($sformatf("v%0d_nreq", i), obs_req.size(), tbl[i].nreq);
      check($sformatf("v%0d_beats", i), obs_beats, tbl[i].nbeats);
      check($sformatf("v%0d_error", i), obs_err, tbl[i].err);
      check($sformatf("v%0d_aborted", i), obs_ab, tbl[i].ab);
      if (tbl[i].nreq > 0 && obs_req.size() > 0) begin
        check($sformatf("v%0d_first_addr", i), obs_req[0].addr, tbl[i].a0);
        check($sformatf("v%0d_last_addr", i), obs_req[obs_req.size()-1].addr, tbl[i].alast);
      end
    end
    check("v1_mem_ffff", dut_mem[16'hFFFF], 16'hAAAA);
    check("v1_mem_0000", dut_mem[16'h0000], 16'h5555);

    for (int k = 0; k < 60; k++) begin
      ra = ($urandom_range(3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(7))) : 16'($urandom);
      run_cmd(1'($urandom_range(1)), ra, LW'($urandom_range(10, 0)), -1, 1'b0, 16'h0, 16'h0, 0);
    end

    // Reset while a read is waiting on memory.
    dly_q.delete(); dly_idx = 0; dly_q.push_back(0); dly_q.push_back(0);
    obs_req.delete(); wq.delete(); wq_idx = 0; abort_no_g = 0; abort_at = -1;
    done_cnt = 0; chk_lat = 1'b0; in_cmd = 1'b0;
    while (cmd_ready !== 1'b1 && done_cnt < 50) begin
      step();
      done_cnt++;
    end
    done_cnt = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0900; cmd_len = 4'd4;
    step();
    cmd_valid = 1'b0;
    for (int g = 0; g < 20 && obs_req.size() == 0; g++) step();
    check("rst_seq_request_seen", obs_req.size(), 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_request", request, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_beats", beats, 0);
    check("mid_rst_request_address", request_address, 0);
    done_cnt = 0;
    nreq0 = obs_req.size();
    repeat (8) step();
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_no_request", obs_req.size(), nreq0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
